// File: rtl/exc_irq_ctrl.sv
// MEM-stage exception/interrupt control: control registers, IRQ pending latches,
// vectored exception entry, nested pre-status/EPC stack, flush and redirect PC.
module exc_irq_ctrl #(
  parameter int unsigned IRQ_CH      = 8,
  parameter int unsigned ADDR_W      = 30,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned EXP_W       = 3,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned VEC_SHIFT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        creg_rd_addr,
  output logic [DATA_W-1:0] creg_rd_data,
  output logic              exe_mode,
  input  logic [IRQ_CH-1:0] irq,
  output logic              int_detect,
  input  logic              mem_en,
  input  logic [ADDR_W-1:0] mem_pc,
  input  logic              mem_br_flag,
  input  logic [1:0]        mem_ctrl_op,
  input  logic [4:0]        mem_dst_addr,
  input  logic [EXP_W-1:0]  mem_exp_code,
  input  logic [DATA_W-1:0] mem_out,
  input  logic              stall,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc
);

  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned ID_W    = (IRQ_CH > 1) ? $clog2(IRQ_CH) : 1;
  localparam logic [1:0]  OP_EXRT = 2'd1;
  localparam logic [1:0]  OP_WRCR = 2'd2;

  logic              int_en, vec_en, ovf, udf;
  logic [IRQ_CH-1:0] mask, edge_sel, pend, irq_d;
  logic [DEPTH_W-1:0] depth;
  logic              stk_mode [STACK_DEPTH];
  logic              stk_ie   [STACK_DEPTH];
  logic [ADDR_W-1:0] stk_epc  [STACK_DEPTH];
  logic [ADDR_W-1:0] exp_vector, pre_pc;
  logic [EXP_W-1:0]  exp_code;
  logic              dly_flag, br_flag;

  logic              has_top, full;
  logic [IDX_W-1:0]  top_idx, push_idx;
  logic              top_mode, top_ie;
  logic [ADDR_W-1:0] top_epc;
  logic              is_exp, is_exrt, is_wrcr, upd;
  logic [IRQ_CH-1:0] active, pend_clr, pend_nxt;
  logic              int_found;
  logic [ID_W-1:0]   int_idx;

  // Stack-top view; depth counts valid entries so the top sits at depth-1
  always_comb begin
    has_top  = (depth != '0);
    full     = (depth == DEPTH_W'(STACK_DEPTH));
    top_idx  = IDX_W'(depth - DEPTH_W'(1));
    push_idx = full ? IDX_W'(STACK_DEPTH - 1) : IDX_W'(depth);
    top_mode = has_top ? stk_mode[top_idx] : 1'b0;
    top_ie   = has_top ? stk_ie[top_idx]   : 1'b0;
    top_epc  = has_top ? stk_epc[top_idx]  : '0;
  end

  // Action decode: exception beats EXRT beats WRCR
  always_comb begin
    is_exp  = mem_en && (mem_exp_code != '0);
    is_exrt = mem_en && !is_exp && (mem_ctrl_op == OP_EXRT);
    is_wrcr = mem_en && !is_exp && !is_exrt && (mem_ctrl_op == OP_WRCR);
    upd     = mem_en && !stall;
  end

  always_comb begin
    flush  = 1'b0;
    new_pc = '0;
    if (is_exp) begin
      flush  = 1'b1;
      new_pc = vec_en ? exp_vector + (ADDR_W'(mem_exp_code) << VEC_SHIFT) : exp_vector;
    end else if (is_exrt) begin
      flush  = 1'b1;
      new_pc = has_top ? top_epc : exp_vector;
    end else if (is_wrcr) begin
      flush  = 1'b1;
      new_pc = mem_pc;
    end
  end

  // Pending latches: level follows irq, edge is sticky; a same-cycle set beats a clear
  always_comb begin
    pend_clr = '0;
    if (upd && is_wrcr && mem_dst_addr == 5'd7)
      pend_clr = mem_out[IRQ_CH-1:0] & edge_sel;
    pend_nxt = (edge_sel & ((pend & ~pend_clr) | (irq & ~irq_d))) | (~edge_sel & irq);
  end

  always_comb begin
    active    = pend & ~mask;
    int_found = 1'b0;
    int_idx   = '0;
    for (int i = int'(IRQ_CH) - 1; i >= 0; i--) begin
      if (active[i]) begin
        int_found = 1'b1;
        int_idx   = ID_W'(i);
      end
    end
    int_detect = int_en && (active != '0);
  end

  always_comb begin
    creg_rd_data = '0;
    case (creg_rd_addr)
      5'd0:    creg_rd_data = DATA_W'({udf, ovf, vec_en, int_en, exe_mode});
      5'd1:    creg_rd_data = DATA_W'({top_ie, top_mode});
      5'd3:    creg_rd_data = DATA_W'({top_epc, 2'b00});
      5'd4:    creg_rd_data = DATA_W'({exp_vector, 2'b00});
      5'd5:    creg_rd_data = DATA_W'({dly_flag, exp_code});
      5'd6:    creg_rd_data = DATA_W'(mask);
      5'd7:    creg_rd_data = DATA_W'(pend);
      5'd8:    creg_rd_data = DATA_W'(edge_sel);
      5'd9:    creg_rd_data = DATA_W'(depth);
      5'd10:   creg_rd_data = int_found ? DATA_W'(int_idx) : '1;
      default: creg_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exe_mode   <= 1'b0;
      int_en     <= 1'b0;
      vec_en     <= 1'b0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
      mask       <= '1;
      edge_sel   <= '0;
      pend       <= '0;
      irq_d      <= '0;
      depth      <= '0;
      exp_vector <= '0;
      exp_code   <= '0;
      dly_flag   <= 1'b0;
      pre_pc     <= '0;
      br_flag    <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        stk_mode[i] <= 1'b0;
        stk_ie[i]   <= 1'b0;
        stk_epc[i]  <= '0;
      end
    end else begin
      irq_d <= irq;
      pend  <= pend_nxt;
      if (upd) begin
        pre_pc  <= mem_pc;
        br_flag <= mem_br_flag;
        if (is_exp) begin
          // Full stack overwrites the deepest slot and flags overflow
          stk_mode[push_idx] <= exe_mode;
          stk_ie[push_idx]   <= int_en;
          stk_epc[push_idx]  <= pre_pc;
          if (full) ovf <= 1'b1;
          else      depth <= depth + DEPTH_W'(1);
          exe_mode <= 1'b0;
          int_en   <= 1'b0;
          exp_code <= mem_exp_code;
          dly_flag <= br_flag;
        end else if (is_exrt) begin
          if (has_top) begin
            exe_mode <= top_mode;
            int_en   <= top_ie;
            depth    <= depth - DEPTH_W'(1);
          end else begin
            udf <= 1'b1;
          end
        end else if (is_wrcr) begin
          case (mem_dst_addr)
            5'd0: begin
              exe_mode <= mem_out[0];
              int_en   <= mem_out[1];
              vec_en   <= mem_out[2];
              ovf      <= mem_out[3];
              udf      <= mem_out[4];
            end
            5'd1: if (has_top) begin
              stk_mode[top_idx] <= mem_out[0];
              stk_ie[top_idx]   <= mem_out[1];
            end
            5'd3: if (has_top) stk_epc[top_idx] <= mem_out[ADDR_W+1:2];
            5'd4: exp_vector <= mem_out[ADDR_W+1:2];
            5'd5: begin
              exp_code <= mem_out[EXP_W-1:0];
              dly_flag <= mem_out[EXP_W];
            end
            5'd6: mask     <= mem_out[IRQ_CH-1:0];
            5'd8: edge_sel <= mem_out[IRQ_CH-1:0];
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Directed plus randomized bench for exc_irq_ctrl against a queue-based reference model.
module tb_exc_irq_ctrl;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  creg_rd_addr;
  logic [31:0] creg_rd_data;
  logic        exe_mode;
  logic [7:0]  irq;
  logic        int_detect;
  logic        mem_en;
  logic [29:0] mem_pc;
  logic        mem_br_flag;
  logic [1:0]  mem_ctrl_op;
  logic [4:0]  mem_dst_addr;
  logic [2:0]  mem_exp_code;
  logic [31:0] mem_out;
  logic        stall;
  logic        flush;
  logic [29:0] new_pc;

  exc_irq_ctrl dut (
    .clk(clk), .reset(reset), .creg_rd_addr(creg_rd_addr), .creg_rd_data(creg_rd_data),
    .exe_mode(exe_mode), .irq(irq), .int_detect(int_detect), .mem_en(mem_en),
    .mem_pc(mem_pc), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
    .mem_dst_addr(mem_dst_addr), .mem_exp_code(mem_exp_code), .mem_out(mem_out),
    .stall(stall), .flush(flush), .new_pc(new_pc)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  typedef struct packed { logic mode; logic ie; logic [29:0] epc; } ent_t;
  ent_t        stk[$];
  logic        m_mode, m_ie, m_vec, m_ovf, m_udf, m_dly, m_br, mv;
  logic [7:0]  m_mask, m_edge, m_pend, m_irqd;
  logic [29:0] m_expvec, m_prepc;
  logic [2:0]  m_code;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] r;
    logic [7:0]  act;
    int          n;
    n   = stk.size();
    act = m_pend & ~m_mask;
    r   = 32'h0;
    case (a)
      5'd0:  r = {27'h0, m_udf, m_ovf, m_vec, m_ie, m_mode};
      5'd1:  if (n > 0) r = {30'h0, stk[n-1].ie, stk[n-1].mode};
      5'd3:  if (n > 0) r = {stk[n-1].epc, 2'b00};
      5'd4:  r = {m_expvec, 2'b00};
      5'd5:  r = {28'h0, m_dly, m_code};
      5'd6:  r = {24'h0, m_mask};
      5'd7:  r = {24'h0, m_pend};
      5'd8:  r = {24'h0, m_edge};
      5'd9:  r = 32'(n);
      5'd10: begin
        r = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) if (act[i]) begin r = 32'(i); break; end
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic m_comb(output logic f, output logic [29:0] pc);
    int n;
    n  = stk.size();
    f  = 1'b0;
    pc = 30'h0;
    if (mem_en) begin
      if (mem_exp_code != 3'd0) begin
        f  = 1'b1;
        pc = m_vec ? m_expvec + (30'(mem_exp_code) * 30'd4) : m_expvec;
      end else if (mem_ctrl_op == 2'd1) begin
        f  = 1'b1;
        pc = (n > 0) ? stk[n-1].epc : m_expvec;
      end else if (mem_ctrl_op == 2'd2) begin
        f  = 1'b1;
        pc = mem_pc;
      end
    end
  endtask

  task automatic m_update();
    logic [7:0]  clr, rise;
    logic [29:0] old_pc;
    logic        old_br;
    ent_t        e;
    int          n;
    if (reset) begin
      m_mode = 0; m_ie = 0; m_vec = 0; m_ovf = 0; m_udf = 0; m_dly = 0; m_br = 0;
      m_mask = 8'hFF; m_edge = 0; m_pend = 0; m_irqd = 0;
      m_expvec = 0; m_prepc = 0; m_code = 0;
      stk.delete();
      return;
    end
    n    = stk.size();
    rise = irq & ~m_irqd;
    clr  = 8'h0;
    if (mem_en && !stall && mem_exp_code == 3'd0 && mem_ctrl_op == 2'd2 && mem_dst_addr == 5'd7)
      clr = mem_out[7:0] & m_edge;
    for (int i = 0; i < 8; i++)
      m_pend[i] = m_edge[i] ? ((m_pend[i] & ~clr[i]) | rise[i]) : irq[i];
    m_irqd = irq;
    if (!mem_en || stall) return;
    old_pc = m_prepc; old_br = m_br;
    m_prepc = mem_pc; m_br = mem_br_flag;
    if (mem_exp_code != 3'd0) begin
      e.mode = m_mode; e.ie = m_ie; e.epc = old_pc;
      if (n == SD) begin stk[SD-1] = e; m_ovf = 1; end
      else stk.push_back(e);
      m_mode = 0; m_ie = 0; m_code = mem_exp_code; m_dly = old_br;
    end else if (mem_ctrl_op == 2'd1) begin
      if (n > 0) begin e = stk.pop_back(); m_mode = e.mode; m_ie = e.ie; end
      else m_udf = 1;
    end else if (mem_ctrl_op == 2'd2) begin
      case (mem_dst_addr)
        5'd0: begin
          m_mode = mem_out[0]; m_ie = mem_out[1]; m_vec = mem_out[2];
          m_ovf = mem_out[3]; m_udf = mem_out[4];
        end
        5'd1: if (n > 0) begin e = stk[n-1]; e.mode = mem_out[0]; e.ie = mem_out[1]; stk[n-1] = e; end
        5'd3: if (n > 0) begin e = stk[n-1]; e.epc = mem_out[31:2]; stk[n-1] = e; end
        5'd4: m_expvec = mem_out[31:2];
        5'd5: begin m_code = mem_out[2:0]; m_dly = mem_out[3]; end
        5'd6: m_mask = mem_out[7:0];
        5'd8: m_edge = mem_out[7:0];
        default: ;
      endcase
    end
  endtask

  // One clock: compare against the model mid-cycle, then advance the model at the edge
  task automatic tick();
    logic        ef;
    logic [29:0] epc;
    @(negedge clk);
    if (mv) begin
      m_comb(ef, epc);
      chk("flush", 32'(flush), 32'(ef));
      chk("new_pc", 32'(new_pc), 32'(epc));
      chk("int_detect", 32'(int_detect), 32'(m_ie && ((m_pend & ~m_mask) != 8'h0)));
      chk("exe_mode", 32'(exe_mode), 32'(m_mode));
      chk("rd_data", creg_rd_data, m_read(creg_rd_addr));
    end
    @(posedge clk);
    m_update();
    mv = 1'b1;
    #1;
  endtask

  task automatic idle();
    reset = 0; mem_en = 0; mem_ctrl_op = 0; mem_exp_code = 0; stall = 0;
    mem_dst_addr = 0; mem_out = 0; mem_br_flag = 0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    creg_rd_addr = a;
    #1;
    chk(tag, creg_rd_data, exp);
  endtask

  task automatic wrcr(input logic [4:0] dst, input logic [31:0] d, input logic [29:0] pc);
    idle();
    mem_en = 1; mem_ctrl_op = 2'd2; mem_dst_addr = dst; mem_out = d; mem_pc = pc;
    tick();
    idle();
  endtask

  task automatic exc(input logic [2:0] code, input logic [29:0] pc);
    idle();
    mem_en = 1; mem_exp_code = code; mem_pc = pc;
    tick();
    idle();
  endtask

  task automatic exrt();
    idle();
    mem_en = 1; mem_ctrl_op = 2'd1;
    tick();
    idle();
  endtask

  initial begin
    mv = 0; irq = 0; mem_pc = 0; creg_rd_addr = 0;
    idle();
    reset = 1;
    tick(); tick();
    idle();

    // Reset state
    rd("rst_status", 5'd0, 32'h0);
    rd("rst_mask", 5'd6, 32'hFF);
    rd("rst_depth", 5'd9, 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_int_detect", 32'(int_detect), 32'h0);
    rd("rst_int_id", 5'd10, 32'hFFFF_FFFF);

    // Edge pending latch, write-1-to-clear, set beats clear
    wrcr(5'd6, 32'hFE, 30'h10);
    wrcr(5'd0, 32'h2, 30'h11);
    wrcr(5'd8, 32'h1, 30'h12);
    irq = 8'h01; tick(); irq = 8'h00;
    rd("edge_pend_set", 5'd7, 32'h1);
    chk("edge_int_detect", 32'(int_detect), 32'h1);
    rd("edge_int_id", 5'd10, 32'h0);
    tick();
    rd("edge_pend_hold", 5'd7, 32'h1);
    wrcr(5'd7, 32'h1, 30'h13);
    rd("edge_pend_clr", 5'd7, 32'h0);
    chk("edge_int_clr", 32'(int_detect), 32'h0);
    idle();
    mem_en = 1; mem_ctrl_op = 2'd2; mem_dst_addr = 5'd7; mem_out = 32'h1; mem_pc = 30'h14;
    irq = 8'h01;
    tick(); idle();
    rd("set_beats_clr", 5'd7, 32'h1);
    irq = 8'h00;
    wrcr(5'd7, 32'h1, 30'h15);
    rd("edge_pend_clr2", 5'd7, 32'h0);

    // Vectored exception entry
    wrcr(5'd0, 32'h6, 30'h16);
    wrcr(5'd4, 32'h400, 30'h55);
    mem_en = 1; mem_exp_code = 3'd3; mem_pc = 30'h60;
    #1;
    chk("vec_flush", 32'(flush), 32'h1);
    chk("vec_new_pc", 32'(new_pc), 32'h10C);
    tick(); idle();
    chk("exc_mode", 32'(exe_mode), 32'h0);
    rd("exc_status", 5'd0, 32'h4);
    rd("exc_depth", 5'd9, 32'h1);
    rd("exc_epc", 5'd3, 32'h154);
    rd("exc_cause", 5'd5, 32'h3);

    // Nesting past the stack depth, then unwinding in LIFO order
    for (int k = 0; k < 4; k++) begin
      wrcr(5'd0, 32'h4 | 32'(k & 3), 30'(32'h200 + k));
      exc(3'd1, 30'(32'h300 + k));
    end
    rd("ovf_depth", 5'd9, 32'h4);
    creg_rd_addr = 5'd0; #1;
    chk("ovf_flag", (creg_rd_data >> 3) & 32'h1, 32'h1);
    mem_en = 1; mem_ctrl_op = 2'd1; #1;
    chk("exrt_top_epc", 32'(new_pc), 32'h203);
    idle();
    for (int k = 0; k < 4; k++) begin
      exrt();
      rd("exrt_depth", 5'd9, 32'(3 - k));
    end
    chk("exrt_final_mode", 32'(exe_mode), 32'h0);
    mem_en = 1; mem_ctrl_op = 2'd1; #1;
    chk("udf_new_pc", 32'(new_pc), 32'h100);
    tick(); idle();
    creg_rd_addr = 5'd0; #1;
    chk("udf_flag", (creg_rd_data >> 4) & 32'h1, 32'h1);
    rd("udf_epc_zero", 5'd3, 32'h0);

    // Stalled exception updates once
    wrcr(5'd0, 32'h0, 30'h20);
    mem_en = 1; mem_exp_code = 3'd2; mem_pc = 30'h70; stall = 1;
    #1;
    chk("stall_flush", 32'(flush), 32'h1);
    tick(); tick();
    rd("stall_depth", 5'd9, 32'h0);
    stall = 0;
    tick(); idle();
    rd("unstall_depth", 5'd9, 32'h1);
    tick();
    rd("unstall_once", 5'd9, 32'h1);

    // Exception beats EXRT; mem_en gates everything
    mem_en = 1; mem_exp_code = 3'd2; mem_ctrl_op = 2'd1; mem_pc = 30'h80;
    #1;
    chk("prio_new_pc", 32'(new_pc), 32'h100);
    tick(); idle();
    rd("prio_depth", 5'd9, 32'h2);
    mem_exp_code = 3'd5; mem_ctrl_op = 2'd2;
    #1;
    chk("noen_flush", 32'(flush), 32'h0);
    chk("noen_new_pc", 32'(new_pc), 32'h0);
    tick();

    // Reset overrides a concurrent exception
    idle();
    mem_en = 1; mem_exp_code = 3'd1; reset = 1;
    tick(); idle();
    rd("midrst_depth", 5'd9, 32'h0);
    rd("midrst_mask", 5'd6, 32'hFF);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      reset        = ($urandom_range(0, 199) == 0);
      mem_en       = ($urandom_range(0, 9) < 7);
      stall        = ($urandom_range(0, 4) == 0);
      mem_exp_code = ($urandom_range(0, 6) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      mem_ctrl_op  = 2'($urandom_range(0, 3));
      mem_dst_addr = 5'($urandom_range(0, 11));
      mem_out      = $urandom;
      mem_pc       = 30'($urandom);
      mem_br_flag  = 1'($urandom);
      irq          = irq ^ 8'($urandom & $urandom);
      creg_rd_addr = 5'($urandom_range(0, 15));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
